// File: rtl/mac_array_ctrl.sv
// rtl/mac_array_ctrl.sv - MAC array sequencer: kernel load, propagation wait, activation stream, output drain.
module mac_array_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int num_act = 36,
    parameter int aw      = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [aw-1:0]     w_base,
    input  logic [aw-1:0]     a_base,
    output logic              sram_cen,
    output logic [aw-1:0]     sram_addr,
    output logic [2*row-1:0]  inst_w,
    input  logic              ofifo_valid,
    output logic              ofifo_rd,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KLOAD,
        S_KWAIT,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int MAXC = (num_act > row + col) ? num_act : row + col;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int PW   = $clog2(num_act + 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           pop_q, pop_d;
    logic [aw-1:0]           w_base_q, w_base_d;
    logic [aw-1:0]           a_base_q, a_base_d;
    logic [row-1:0][1:0]     skew_q, skew_d;
    logic [1:0]              inst0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pop_d     = pop_q;
        w_base_d  = w_base_q;
        a_base_d  = a_base_q;
        sram_cen  = 1'b1;
        sram_addr = '0;
        inst0     = 2'b00;
        ofifo_rd  = 1'b0;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_KLOAD;
                    cnt_d    = '0;
                    pop_d    = '0;
                    w_base_d = w_base;
                    a_base_d = a_base;
                end
            end
            S_KLOAD: begin
                sram_cen  = 1'b0;
                sram_addr = w_base_q + aw'(cnt_q);
                inst0     = 2'b01;
                if (cnt_q == CW'(col - 1)) begin
                    state_d = S_KWAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_KWAIT: begin
                if (cnt_q == CW'(row + col - 1)) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXEC: begin
                sram_cen  = 1'b0;
                sram_addr = a_base_q + aw'(cnt_q);
                inst0     = 2'b10;
                ofifo_rd  = ofifo_valid && (pop_q != PW'(num_act));
                if (cnt_q == CW'(num_act - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                ofifo_rd = ofifo_valid && (pop_q != PW'(num_act));
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (ofifo_rd) begin
            pop_d = pop_q + 1'b1;
        end
        // A pop in the final EXEC cycle is already counted when DRAIN is entered.
        if (state_q == S_DRAIN && pop_d == PW'(num_act)) begin
            state_d = S_DONE;
        end

        skew_d[0] = inst0;
        for (int r = 1; r < row; r++) begin
            skew_d[r] = skew_q[r-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pop_q    <= '0;
            w_base_q <= '0;
            a_base_q <= '0;
            skew_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pop_q    <= pop_d;
            w_base_q <= w_base_d;
            a_base_q <= a_base_d;
            skew_q   <= skew_d;
        end
    end

    assign inst_w = skew_q;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb/tb_mac_array_ctrl.sv - directed scenario-table bench for mac_array_ctrl.
module tb_mac_array_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int NA  = 36;
    localparam int AW  = 11;
    localparam int EX0 = 1 + COL + ROW + COL;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [AW-1:0]     w_base;
    logic [AW-1:0]     a_base;
    logic              sram_cen;
    logic [AW-1:0]     sram_addr;
    logic [2*ROW-1:0]  inst_w;
    logic              ofifo_valid;
    logic              ofifo_rd;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    mac_array_ctrl #(.row(ROW), .col(COL), .num_act(NA), .aw(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .w_base     (w_base),
        .a_base     (a_base),
        .sram_cen   (sram_cen),
        .sram_addr  (sram_addr),
        .inst_w     (inst_w),
        .ofifo_valid(ofifo_valid),
        .ofifo_rd   (ofifo_rd),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // vmode 0: valid from first EXEC cycle; 1: low in EXEC then 1/0 toggle; 2: always high
    typedef struct {
        logic [AW-1:0] w;
        logic [AW-1:0] a;
        int            vmode;
        bit            glitch;
        int            done_cyc;
    } scen_t;

    scen_t tbl [4];

    function automatic void chk(input string nm, input int c, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, c, act, exp);
        end
    endfunction

    function automatic logic [1:0] exp_slice(input int c, input int r);
        if (c >= 2 + r && c <= COL + 1 + r)          return 2'b01;
        if (c >= EX0 + 1 + r && c <= EX0 + NA + r)   return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic valid_fn(input int vmode, input int c);
        case (vmode)
            0:       return c >= EX0;
            1:       return (c >= EX0 + NA) && ((c - (EX0 + NA)) % 2 == 0);
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_pass(input scen_t s);
        int            epops;
        int            dpops;
        int            dones;
        bit            kl;
        bit            ex;
        logic          erd;
        logic [AW-1:0] ea;
        epops = 0;
        dpops = 0;
        dones = 0;
        for (int c = 0; c <= s.done_cyc + 10; c++) begin
            @(negedge clk);
            start       = (c == 0) || (s.glitch && (c == 12 || c == s.done_cyc));
            w_base      = (c == 0) ? s.w : 11'h555;
            a_base      = (c == 0) ? s.a : 11'h2AA;
            ofifo_valid = valid_fn(s.vmode, c);
            #1;
            kl = (c >= 1 && c <= COL);
            ex = (c >= EX0 && c < EX0 + NA);
            chk("sram_cen", c, 32'(sram_cen), 32'(!(kl || ex)));
            if (kl) begin
                ea = s.w + AW'(c - 1);
                chk("kload_addr", c, 32'(sram_addr), 32'(ea));
            end else if (ex) begin
                ea = s.a + AW'(c - EX0);
                chk("exec_addr", c, 32'(sram_addr), 32'(ea));
            end else if (c == 0 || c > s.done_cyc) begin
                chk("idle_addr", c, 32'(sram_addr), 32'd0);
            end
            for (int r = 0; r < ROW; r++) begin
                chk($sformatf("inst_slice%0d", r), c, 32'(inst_w[2*r +: 2]),
                    32'(exp_slice(c, r)));
            end
            erd = ofifo_valid && c >= EX0 && c < s.done_cyc && epops < NA;
            if (erd) epops++;
            chk("ofifo_rd", c, 32'(ofifo_rd), 32'(erd));
            if (ofifo_rd) dpops++;
            if (done) dones++;
            chk("done", c, 32'(done), 32'(c == s.done_cyc));
            chk("busy", c, 32'(busy), 32'(c >= 1 && c <= s.done_cyc));
        end
        chk("total_pops", s.done_cyc, dpops, NA);
        chk("done_pulses", s.done_cyc, dones, 1);
    endtask

    initial begin
        int saw_done;

        tbl[0] = '{w: 11'h010, a: 11'h100, vmode: 0, glitch: 1'b0, done_cyc: EX0 + NA + 1};
        tbl[1] = '{w: 11'h7FC, a: 11'h7F0, vmode: 0, glitch: 1'b0, done_cyc: EX0 + NA + 1};
        tbl[2] = '{w: 11'h020, a: 11'h200, vmode: 1, glitch: 1'b0, done_cyc: EX0 + NA + 71};
        tbl[3] = '{w: 11'h010, a: 11'h100, vmode: 2, glitch: 1'b1, done_cyc: EX0 + NA + 1};

        reset       = 1'b0;
        start       = 1'b1;
        w_base      = 11'h3C3;
        a_base      = 11'h3C3;
        ofifo_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_cen", 0, 32'(sram_cen), 32'd1);
        chk("rst_addr", 0, 32'(sram_addr), 32'd0);
        chk("rst_inst", 0, 32'(inst_w), 32'd0);
        chk("rst_rd", 0, 32'(ofifo_rd), 32'd0);
        chk("rst_done", 0, 32'(done), 32'd0);
        @(negedge clk);
        reset       = 1'b1;
        start       = 1'b0;
        ofifo_valid = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_pass(tbl[i]);
        end

        // Reset in the 5th EXEC cycle aborts the pass and flushes the skew chain.
        for (int c = 0; c <= EX0 + 5; c++) begin
            @(negedge clk);
            start       = (c == 0);
            w_base      = 11'h010;
            a_base      = 11'h100;
            ofifo_valid = 1'b1;
            reset       = !(c == EX0 + 4);
            #1;
            if (c == EX0 + 4) begin
                chk("abort_pre_addr", c, 32'(sram_addr), 32'h104);
                chk("abort_pre_inst", c, 32'(inst_w[1:0]), 32'h2);
            end
            if (c == EX0 + 5) begin
                chk("abort_inst", c, 32'(inst_w), 32'd0);
                chk("abort_cen", c, 32'(sram_cen), 32'd1);
                chk("abort_busy", c, 32'(busy), 32'd0);
                chk("abort_rd", c, 32'(ofifo_rd), 32'd0);
            end
        end
        saw_done = 0;
        repeat (60) begin
            @(negedge clk);
            #1;
            if (done) saw_done++;
        end
        chk("abort_no_done", 0, saw_done, 0);
        ofifo_valid = 1'b0;

        run_pass(tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
